// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t : sequencer states (IDLE, CONV, DONE)
//   DIG_W   : bits per BCD digit
//   DIG_MAX : largest legal BCD digit value
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIG_W   = 4;
    localparam logic [3:0]  DIG_MAX = 4'd9;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step for the BCD converter.
// Ports:
//   acc           in  W      running binary value
//   digit         in  DIG_W  next BCD digit (MSD first)
//   sum           out W      acc*10 + digit, built from shifts and adds
//   digit_invalid out 1      digit is outside 0..9
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int W = 18
) (
    input  logic [W-1:0]     acc,
    input  logic [DIG_W-1:0] digit,
    output logic [W-1:0]     sum,
    output logic             digit_invalid
);

    // acc*10 = acc*8 + acc*2; no multiplier is inferred.
    assign sum           = (acc << 3) + (acc << 1) + W'(digit);
    assign digit_invalid = (digit > DIG_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first.
// Ports:
//   clk     in  1        clock, rising edge
//   rst     in  1        synchronous active-high reset
//   start   in  1        request, accepted only when idle
//   bcd_in  in  4*NDIG   packed BCD digits, MSD in top nibble
//   busy    out 1        conversion in progress (CONV or DONE)
//   done    out 1        one-cycle pulse, bin/err valid
//   bin     out BW       binary result, held until the next done
//   err     out 1        last request had a digit above 9
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIG_W*NDIG-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BW-1:0]         bin,
    output logic                  err
);

    // Four spare bits cover the transient acc*10 growth, so no input,
    // including ones with illegal digits, can overflow.
    localparam int AW  = BW + 4;
    localparam int SRW = DIG_W * NDIG;
    localparam int IW  = $clog2(NDIG + 1);

    state_t           state;
    state_t           state_next;
    logic [SRW-1:0]   sr;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [IW-1:0]    idx;
    logic             err_flag;
    logic             err_next;
    logic             dig_bad;
    logic             last_dig;
    logic [DIG_W-1:0] digit;

    assign digit    = sr[SRW-1 -: DIG_W];
    assign last_dig = (idx == IW'(NDIG - 1));
    assign err_next = err_flag | dig_bad;

    bcd_mac10 #(.W(AW)) u_mac (
        .acc           (acc),
        .digit         (digit),
        .sum           (acc_next),
        .digit_invalid (dig_bad)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start is only looked at in IDLE, so it never queues.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (last_dig) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath. bin/err change only on the last CONV edge, so they stay
    // stable across a following request until its own done.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            acc      <= '0;
            idx      <= '0;
            err_flag <= 1'b0;
            bin      <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= bcd_in;
                        acc      <= '0;
                        idx      <= '0;
                        err_flag <= 1'b0;
                    end
                end
                CONV: begin
                    acc      <= acc_next;
                    err_flag <= err_next;
                    sr       <= sr << DIG_W;
                    idx      <= idx + IW'(1);
                    if (last_dig) begin
                        bin <= err_next ? '0 : acc_next[BW-1:0];
                        err <= err_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of BCD digits converted per request (1..6).
REQ-002 SHALL have parameter BW, default 14, binary result width; the integrator sets BW >= ceil(log2(10^NDIG)).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  conversion request, sampled on the rising edge of clk.
REQ-006 SHALL have port bcd_in  input  4*NDIG  packed BCD digits, most-significant digit in the top nibble.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-009 SHALL have port bin  output  BW  unsigned binary result, held between conversions.
REQ-010 SHALL have port err  output  1  set when the last request contained a digit greater than 9.

Function
REQ-011 SHALL implement FSM states IDLE, CONV and DONE.
REQ-012 SHALL, in IDLE with start=1 at edge k, capture bcd_in into a digit shift register, clear the accumulator, clear the error flag, load the digit index with 0 and enter CONV.
REQ-013 SHALL ignore start in CONV and DONE; a start request is not queued.
REQ-014 SHALL, in CONV, consume one digit per cycle, MSD first, with acc <= acc*10 + digit; acc*10 SHALL be formed as (acc<<3)+(acc<<1), without a multiplier.
REQ-015 SHALL size the accumulator and the intermediate sum to BW+4 bits, so that no overflow occurs for any input.
REQ-016 SHALL set the error flag if any consumed digit is in the range 1010..1111; the flag is sticky for the rest of the request.
REQ-017 SHALL, after NDIG CONV cycles (at edge k+NDIG), load bin with acc[BW-1:0], or with 0 if the error flag is set, drive err from the error flag and enter DONE.
REQ-018 SHALL assert done only in DONE, for exactly one cycle (the cycle after edge k+NDIG), then return to IDLE.
REQ-019 SHALL drive busy = 1 in CONV and DONE and 0 in IDLE; the first new start is accepted at edge k+NDIG+2.
REQ-020 SHALL hold bin and err stable from the done pulse until the next done pulse; a new start SHALL NOT disturb them before its own done.
REQ-021 SHALL sample bcd_in only at the accepting edge; changes on bcd_in during CONV SHALL have no effect.
REQ-022 SHALL handle all-zero input (bin=0, err=0) and the all-nines maximum 10^NDIG-1 without special cases.

Reset
REQ-023 SHALL, with rst=1 at any edge, including mid-CONV or DONE, enter IDLE and clear busy, done, err and bin to 0, the accumulator, the digit index and the shift register; rst SHALL take priority over start.
REQ-024 SHALL accept start at the first edge with rst=0.

Structure
REQ-025 SHALL take the state typedef (IDLE/CONV/DONE), the digit-width constant 4 and the maximum-digit constant 9 from shared package bcd_pkg.
REQ-026 SHALL instantiate one combinational sub-module bcd_mac10 (inputs acc, digit; outputs acc*10+digit and digit_invalid); all sequencing stays in the top level.
REQ-027 SHALL contain no latches, no multipliers and a single clock domain.

Verification
REQ-028 SHALL verify: NDIG=4, start with bcd_in=0x1234 -> busy high for 5 cycles, done pulse at edge k+4 output, bin=1234 (0x04D2), err=0.
REQ-029 SHALL verify: bcd_in=0x9999 -> bin=9999 (0x270F); bcd_in=0x0000 -> bin=0; done exactly one cycle wide in both cases.
REQ-030 SHALL verify: bcd_in=0x12A4 -> err=1, bin=0; a following request with 0x0042 -> err=0, bin=42.
REQ-031 SHALL verify: start held high continuously with bcd_in changing every cycle -> conversions accepted every NDIG+2 cycles, each result matching bcd_in at its accepting edge.
REQ-032 SHALL verify: rst asserted 2 cycles into a conversion -> next edge busy=0, done=0, bin=0, err=0, and no done pulse follows.
REQ-033 SHALL verify: with NDIG=6 and BW=20, bcd_in=0x999999 -> bin=999999 (0xF423F).
